// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, egress FSM states
// and the 32-bit FIFO/link word type.
package router_pkg;

  localparam int LEN_W_DEF    = 8;
  localparam int DEST_LSB_DEF = 24;
  localparam int DEST_W       = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

endpackage

// File: rtl/pkt_len_counter.sv
// Payload word counter for pkt_egress: loads the header length,
// counts popped payload words down and flags last/zero-length.
module pkt_len_counter
  import router_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_zero,
  output logic             o_last
);

  logic [LEN_W-1:0] r_rem;

  // Load on header pop, count down on payload pop, never wrap below 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_len;
    end else if (i_dec && (r_rem != '0)) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  assign o_zero = (i_len == '0);
  assign o_last = (r_rem == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pkt_egress.sv
// Port FIFO drain and packet framer onto a valid/ready stream.
// Optional counters enabled by defining PKT_EGRESS_STATS_EN.
module pkt_egress
  import router_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEF,
  parameter int DEST_LSB = DEST_LSB_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fifo_empty,
  input  word_t             fifo_dout,
  output logic              fifo_pop,
  output word_t             out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [DEST_W-1:0] out_dest,
  output logic              busy
`ifdef PKT_EGRESS_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [15:0]       underrun_count
`endif
);

  state_t            r_state;
  word_t             r_data;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [DEST_W-1:0] r_dest;

  logic w_free;
  logic w_pop;
  logic w_hdr_pop;
  logic w_pay_pop;
  logic w_zero;
  logic w_last;

  assign w_free    = !r_valid || out_ready;
  assign w_pop     = reset_n && !fifo_empty && w_free;
  assign w_hdr_pop = w_pop && (r_state == IDLE);
  assign w_pay_pop = w_pop && (r_state == PAYLOAD);

  pkt_len_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_hdr_pop),
    .i_dec   (w_pay_pop),
    .i_len   (fifo_dout[LEN_W-1:0]),
    .o_zero  (w_zero),
    .o_last  (w_last)
  );

  // Output register and framing FSM; pop and load share one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_dest  <= '0;
    end else if (w_pop) begin
      r_data  <= fifo_dout;
      r_valid <= 1'b1;
      unique case (1'b1)
        w_hdr_pop: begin
          r_sop   <= 1'b1;
          r_eop   <= w_zero;
          r_dest  <= fifo_dout[DEST_LSB +: DEST_W];
          r_state <= w_zero ? IDLE : PAYLOAD;
        end
        w_pay_pop: begin
          r_sop   <= 1'b0;
          r_eop   <= w_last;
          r_state <= w_last ? IDLE : PAYLOAD;
        end
        default: begin
          r_sop <= r_sop;
        end
      endcase
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

  assign fifo_pop  = w_pop;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sop   = r_sop;
  assign out_eop   = r_eop;
  assign out_dest  = r_dest;
  assign busy      = (r_state == PAYLOAD);

`ifdef PKT_EGRESS_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_urun_cnt;

  // Wrapping accepted-packet count and saturating underrun-cycle count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt  <= '0;
      r_urun_cnt <= '0;
    end else begin
      if (r_valid && out_ready && r_eop)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if ((r_state == PAYLOAD) && w_free && fifo_empty &&
          (r_urun_cnt != 16'hFFFF))
        r_urun_cnt <= r_urun_cnt + 16'd1;
    end
  end

  assign pkt_count      = r_pkt_cnt;
  assign underrun_count = r_urun_cnt;
`endif

endmodule

// File: doc/pkt_egress.md
# pkt_egress

Packet egress reader for the router output port. It drains the 32-bit port FIFO (consumer side of the push/pop interface) and parses packet framing from the header word. It transmits each packet on a valid/ready output stream with start- and end-of-packet markers and honours downstream backpressure. It sits between each port FIFO and the output link driver.

## Interface
- LEN_W, 8, width of header length field (payload word count, header bits [LEN_W-1:0])
- DEST_LSB, 24, LSB of 8-bit destination field in header (bits [DEST_LSB+7:DEST_LSB])

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  32  FIFO head word, valid whenever fifo_empty=0 (first-word fall-through)
- fifo_pop  out  1  consume head word this cycle (combinational)
- out_data  out  32  transmitted word (registered)
- out_valid  out  1  out_data valid
- out_sop  out  1  out_data is header word
- out_eop  out  1  out_data is last word of packet
- out_ready  in  1  downstream accepts word when out_valid=1
- out_dest  out  8  destination of current packet, held from header until next header
- busy  out  1  1 while a packet is partially transmitted (state != IDLE)

## Operation
- States: IDLE (expect header), PAYLOAD (remaining>0).
- Output register "free" when out_valid=0 or out_ready=1.
- fifo_pop = !fifo_empty && free. Pop and register load happen in the same cycle; the FIFO is never popped when empty.
- IDLE + pop: load header; out_sop=1; out_dest=header dest field; remaining=header[LEN_W-1:0]. If length=0, set out_eop=1 and stay in IDLE. Otherwise go to PAYLOAD.
- PAYLOAD + pop: load word; out_sop=0; decrement remaining. out_eop=1 when remaining was 1, then go to IDLE.
- free && fifo_empty: out_valid<=0 (bubble); state and remaining unchanged; mid-packet underrun is legal.
- !free: all output registers hold; fifo_pop=0.
- Length field is unsigned. remaining is LEN_W bits and never wraps; max packet = 2^LEN_W words including header.
- Header bits not in dest/length fields pass through unmodified.

## Timing
- Reset values: out_data=0, out_valid=0, out_sop=0, out_eop=0, out_dest=0, busy=0, state=IDLE, remaining=0. fifo_pop=0 while reset_n=0.
- Latency: head word at FIFO -> out_valid one cycle after the pop edge.
- Throughput: one word/cycle with out_ready held high and FIFO non-empty.
- out_data/out_sop/out_eop remain stable while out_valid=1 && out_ready=0.
- Reset asserted mid-packet: immediate return to reset values. The shared-reset FIFO is cleared too, so there is no resynchronisation.
- busy rises the cycle after a nonzero-length header pop and falls the cycle after the eop word pop.

## Configuration
- PKT_EGRESS_STATS_EN defined: adds output pkt_count[15:0] and output underrun_count[15:0].
  - pkt_count: incremented on each accepted eop word (out_valid && out_ready && out_eop); wraps at 0xFFFF->0.
  - underrun_count: incremented each cycle the block is in PAYLOAD && free && fifo_empty; saturates at 0xFFFF.
  - Both counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package router_pkg holds:
  - header field constants (DEST_LSB default, dest width 8, LEN_W default);
  - state enum {IDLE, PAYLOAD};
  - 32-bit word typedef, also used by the fifo block.
- Natural sub-module: pkt_len_counter, which loads the length, decrements on pop, and flags last word / zero length.
- The output register and FSM stay in pkt_egress.

## Test plan
- Reset: hold reset_n=0 with FIFO holding data -> all outputs 0, fifo_pop=0; release -> first header appears one cycle after pop.
- Single packet, header 0x0500_0003 + payload 0xA,0xB,0xC, out_ready=1 -> 4 consecutive valid words; sop on 0x05000003; eop on 0xC; out_dest=0x05.
- Zero-length header 0x0200_0000, then header 0x0300_0001 + 0xD -> first word carries sop=eop=1; busy stays 0 for it; the second packet follows back-to-back.
- Backpressure: out_ready=0 for 3 cycles mid-payload -> fifo_pop=0 and out_data stable throughout; no word lost or duplicated.
- Underrun: FIFO empties after header of a length-2 packet, refilled 4 cycles later -> out_valid=0 gap, busy=1 during gap; the packet completes with correct eop. With PKT_EGRESS_STATS_EN, underrun_count=4 and pkt_count=1.
- Reset mid-payload (after 1 of 3 payload words) -> outputs return to 0 immediately; the next header after release is parsed as a new packet.
